mherloa_pipe_adder: RTL and testbench



---
 rtl/mherloa_pipe_adder.sv | 205 ++++++++++++++++++++
 tb/tb_mherloa_pipe_adder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mherloa_pipe_adder.sv
// mherloa_pipe_adder: two-stage pipelined MHERLOA approximate adder for the
// APTPU PE accumulate path. Stage 1 produces sum bits [SPLIT-1:0] (approximate
// low part plus exact ripple above it) and the carry out of bit SPLIT-1. Stage 2
// finishes the exact upper add. Valid/ready on both sides, and two saturating
// profiling counters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake (in_ready is combinational)
//   a, b                operands
//   k_cfg               requested approximate-part width for this beat
//   out_valid/out_ready result handshake
//   sum                 result, carry-out in the MSB
//   out_approx          result was produced in approximate mode
//   op_count            consumed results, saturating
//   approx_count        consumed approximate results, saturating
//   clr_stats           synchronous clear of both counters
module mherloa_pipe_adder #(
    parameter int unsigned ADDER_LENGTH  = 32,
    parameter int unsigned SPLIT         = 16,
    parameter int unsigned MAX_IMPRECISE = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ADDER_LENGTH-1:0]           a,
    input  logic [ADDER_LENGTH-1:0]           b,
    input  logic [$clog2(ADDER_LENGTH+1)-1:0] k_cfg,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ADDER_LENGTH:0]             sum,
    output logic                              out_approx,
    output logic [CNT_W-1:0]                  op_count,
    output logic [CNT_W-1:0]                  approx_count,
    input  logic                              clr_stats
);

    localparam int unsigned KW = $clog2(ADDER_LENGTH + 1);
    localparam int unsigned HW = ADDER_LENGTH - SPLIT;

    // Pipeline and counter state
    logic                 s1_valid_q, s1_valid_d;
    logic [SPLIT-1:0]     s1_lo_q, s1_lo_d;
    logic                 s1_c_q, s1_c_d;
    logic [HW-1:0]        s1_ahi_q, s1_ahi_d;
    logic [HW-1:0]        s1_bhi_q, s1_bhi_d;
    logic                 s1_apx_q, s1_apx_d;
    logic                 out_valid_q, out_valid_d;
    logic [ADDER_LENGTH:0] sum_q, sum_d;
    logic                 out_approx_q, out_approx_d;
    logic [CNT_W-1:0]     op_count_q, op_count_d;
    logic [CNT_W-1:0]     approx_count_q, approx_count_d;

    // Stage-1 combinational signals
    logic [KW-1:0]    ke_c;
    int unsigned      ke_n;
    logic [SPLIT-1:0] a_lo, b_lo, lo_keep, lo_apx;
    logic [SPLIT:0]   lo_cin, lo_exact;
    logic             x1, g2, t, c_ke;
    logic [HW:0]      hi_sum;
    logic             s2_en;
    logic             consume;

    assign a_lo = a[SPLIT-1:0];
    assign b_lo = b[SPLIT-1:0];

    // Effective approximate width: widths below 4 fall back to exact, large ones clamp
    always_comb begin
        if (k_cfg < KW'(4)) begin
            ke_c = '0;
        end else if (k_cfg > KW'(MAX_IMPRECISE)) begin
            ke_c = KW'(MAX_IMPRECISE);
        end else begin
            ke_c = k_cfg;
        end
    end

    // Low part: approximate bits below ke, exact ripple from bit ke up to SPLIT
    always_comb begin
        ke_n    = 32'(ke_c);
        x1      = 1'b0;
        g2      = 1'b0;
        c_ke    = 1'b0;
        lo_keep = '0;
        lo_apx  = '0;
        lo_cin  = '0;
        for (int unsigned i = 0; i < SPLIT; i++) begin
            if (i + 1 == ke_n) begin
                x1   = a_lo[i] ^ b_lo[i];
                c_ke = a_lo[i] & b_lo[i];
            end
            if (i + 2 == ke_n) begin
                g2 = a_lo[i] & b_lo[i];
            end
            lo_keep[i] = (i >= ke_n);
        end
        t = x1 & g2;
        for (int unsigned i = 0; i < SPLIT; i++) begin
            if (i + 4 < ke_n) begin
                lo_apx[i] = 1'b1;
            end else if ((i + 4 == ke_n) || (i + 3 == ke_n)) begin
                lo_apx[i] = a_lo[i] | b_lo[i] | t;
            end else if (i + 2 == ke_n) begin
                lo_apx[i] = (a_lo[i] | b_lo[i]) & ~(g2 & ~x1);
            end else if (i + 1 == ke_n) begin
                lo_apx[i] = x1 | g2;
            end
        end
        // ke never exceeds SPLIT, so the injected carry lands at most in the carry-out slot
        for (int unsigned i = 0; i <= SPLIT; i++) begin
            lo_cin[i] = c_ke & (i == ke_n);
        end
        lo_exact = {1'b0, a_lo & lo_keep} + {1'b0, b_lo & lo_keep} + lo_cin;
    end

    // Stage 2 can take a new beat when empty or when its result is leaving
    assign s2_en    = ~out_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_en;
    assign consume  = out_valid_q & out_ready;
    assign hi_sum   = {1'b0, s1_ahi_q} + {1'b0, s1_bhi_q} + (HW+1)'(s1_c_q);

    // Next-state for pipeline and counters
    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_lo_d        = s1_lo_q;
        s1_c_d         = s1_c_q;
        s1_ahi_d       = s1_ahi_q;
        s1_bhi_d       = s1_bhi_q;
        s1_apx_d       = s1_apx_q;
        out_valid_d    = out_valid_q;
        sum_d          = sum_q;
        out_approx_d   = out_approx_q;
        op_count_d     = op_count_q;
        approx_count_d = approx_count_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_lo_d  = lo_exact[SPLIT-1:0] | lo_apx;
                s1_c_d   = lo_exact[SPLIT];
                s1_ahi_d = a[ADDER_LENGTH-1:SPLIT];
                s1_bhi_d = b[ADDER_LENGTH-1:SPLIT];
                s1_apx_d = (ke_c != '0);
            end
        end

        if (s2_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d        = {hi_sum, s1_lo_q};
                out_approx_d = s1_apx_q;
            end
        end

        if (clr_stats) begin
            op_count_d     = '0;
            approx_count_d = '0;
        end else if (consume) begin
            if (op_count_q != '1) begin
                op_count_d = op_count_q + CNT_W'(1);
            end
            if (out_approx_q && (approx_count_q != '1)) begin
                approx_count_d = approx_count_q + CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_lo_q        <= '0;
            s1_c_q         <= 1'b0;
            s1_ahi_q       <= '0;
            s1_bhi_q       <= '0;
            s1_apx_q       <= 1'b0;
            out_valid_q    <= 1'b0;
            sum_q          <= '0;
            out_approx_q   <= 1'b0;
            op_count_q     <= '0;
            approx_count_q <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_lo_q        <= s1_lo_d;
            s1_c_q         <= s1_c_d;
            s1_ahi_q       <= s1_ahi_d;
            s1_bhi_q       <= s1_bhi_d;
            s1_apx_q       <= s1_apx_d;
            out_valid_q    <= out_valid_d;
            sum_q          <= sum_d;
            out_approx_q   <= out_approx_d;
            op_count_q     <= op_count_d;
            approx_count_q <= approx_count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign sum          = sum_q;
    assign out_approx   = out_approx_q;
    assign op_count     = op_count_q;
    assign approx_count = approx_count_q;

endmodule

// File: tb/tb_mherloa_pipe_adder.sv
// Self-checking bench for mherloa_pipe_adder: directed vector table, stall,
// counter and reset sequences, plus a randomized stream against a reference model.
module tb_mherloa_pipe_adder;

    localparam int unsigned AL = 32;
    localparam int unsigned KW = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AL-1:0] a;
    logic [AL-1:0] b;
    logic [KW-1:0] k_cfg;
    logic          out_valid;
    logic          out_ready;
    logic [AL:0]   sum;
    logic          out_approx;
    logic [31:0]   op_count;
    logic [31:0]   approx_count;
    logic          clr_stats;

    mherloa_pipe_adder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .k_cfg        (k_cfg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sum          (sum),
        .out_approx   (out_approx),
        .op_count     (op_count),
        .approx_count (approx_count),
        .clr_stats    (clr_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [5:0]  vk;
        logic [32:0] exp_sum;
        logic        exp_apx;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    logic        exp_apx_q[$];
    logic [31:0] op_m;
    logic [31:0] apx_m;
    logic        last_acc;
    logic        last_in_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: approximate low ke bits from the bit rules, plain integer add above
    function automatic logic [32:0] ref_sum(input logic [31:0] ra, input logic [31:0] rb,
                                            input logic [5:0] rk, output logic apx);
        int          ke;
        logic [63:0] aa, bb, lo, hi;
        logic        x1, g2, t, c;
        if (rk < 6'd4)       ke = 0;
        else if (rk > 6'd16) ke = 16;
        else                 ke = int'(rk);
        aa  = {32'b0, ra};
        bb  = {32'b0, rb};
        apx = (ke != 0);
        if (ke == 0) return 33'(aa + bb);
        x1 = aa[ke-1] ^ bb[ke-1];
        g2 = aa[ke-2] & bb[ke-2];
        t  = x1 & g2;
        lo = (64'd1 << (ke - 4)) - 64'd1;
        lo[ke-4] = aa[ke-4] | bb[ke-4] | t;
        lo[ke-3] = aa[ke-3] | bb[ke-3] | t;
        lo[ke-2] = (aa[ke-2] | bb[ke-2]) & ~(g2 & ~x1);
        lo[ke-1] = x1 | g2;
        c  = aa[ke-1] & bb[ke-1];
        hi = (aa >> ke) + (bb >> ke) + 64'(c);
        return 33'((hi << ke) | lo);
    endfunction

    // One clock: drive inputs, then score the handshakes that the next edge completes
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [5:0] ik, input logic ordy, input logic clr);
        logic [32:0] es;
        logic        ea;
        logic        acc, con;
        @(posedge clk);
        #1;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        k_cfg     = ik;
        out_ready = ordy;
        clr_stats = clr;
        #1;
        acc = in_valid & in_ready;
        con = out_valid & out_ready;
        ea  = 1'b0;
        if (con) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra actual=%h required=none", sum);
            end else begin
                es = exp_q.pop_front();
                ea = exp_apx_q.pop_front();
                check("sb_sum", 64'(sum), 64'(es));
                check("sb_approx", 64'(out_approx), 64'(ea));
            end
        end
        if (clr) begin
            op_m  = 0;
            apx_m = 0;
        end else if (con) begin
            if (op_m != 32'hFFFF_FFFF) op_m++;
            if (ea && apx_m != 32'hFFFF_FFFF) apx_m++;
        end
        if (acc) begin
            es = ref_sum(ia, ib, ik, ea);
            exp_q.push_back(es);
            exp_apx_q.push_back(ea);
        end
        last_acc      = acc;
        last_in_ready = in_ready;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, 6'd0, ordy, 1'b0);
    endtask

    // Empty the pipeline, then one more edge so counters reflect the last consume
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            idle(1'b1);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        idle(1'b1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h0001_8000, 32'h0000_8000, 6'd16, 33'h0_0002_0FFF, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 6'd0,  33'h1_0000_0000, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 6'd16, 33'h0_0000_0FFF, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 6'd2,  33'h0_0000_000C, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 6'd31, 33'h0_0000_0FFF, 1'b1};
        vecs[5] = '{32'h0000_00FF, 32'h0000_0001, 6'd8,  33'h0_0000_00FF, 1'b1};
        vecs[6] = '{32'h0000_000F, 32'h0000_000F, 6'd4,  33'h0_0000_001B, 1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd16, 33'h1_FFFF_BFFF, 1'b1};
        vecs[8] = '{32'h0000_0800, 32'h0000_0400, 6'd12, 33'h0_0000_0CFF, 1'b1};
        vecs[9] = '{32'h0000_00C0, 32'h0000_0040, 6'd8,  33'h0_0000_00FF, 1'b1};

        op_m      = 0;
        apx_m     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        k_cfg     = '0;
        out_ready = 1'b0;
        clr_stats = 1'b0;

        // Reset values
        #23;
        check("rst_out_valid_low", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_out_approx", 64'(out_approx), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_approx_count", 64'(approx_count), 64'd0);

        // Directed vectors with latency check
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i].va, vecs[i].vb, vecs[i].vk, 1'b1, 1'b0);
            check($sformatf("vec%0d_accept", i), 64'(last_acc), 64'd1);
            idle(1'b1);
            check($sformatf("vec%0d_lat1", i), 64'(out_valid), 64'd0);
            idle(1'b1);
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_apx", i), 64'(out_approx), 64'(vecs[i].exp_apx));
        end
        drain("vec");
        check("vec_op_count", 64'(op_count), 64'd10);
        check("vec_approx_count", 64'(approx_count), 64'd8);

        // Mixed k stream, then clear coincident with a consume
        step(1'b0, 32'h0, 32'h0, 6'd0, 1'b1, 1'b1);
        begin
            logic [5:0] ks[4];
            ks[0] = 6'd0; ks[1] = 6'd8; ks[2] = 6'd0; ks[3] = 6'd16;
            for (int i = 0; i < 4; i++) begin
                step(1'b1, $urandom, $urandom, ks[i], 1'b1, 1'b0);
                check($sformatf("mix%0d_accept", i), 64'(last_acc), 64'd1);
            end
        end
        drain("mix");
        check("mix_op_count", 64'(op_count), 64'd4);
        check("mix_approx_count", 64'(approx_count), 64'd2);
        step(1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 6'd8, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_sum0", 64'(sum), 64'(exp_q[0]));
        idle(1'b0);
        check("hold_sum1", 64'(sum), 64'(exp_q[0]));
        check("hold_apx", 64'(out_approx), 64'd1);
        step(1'b0, 32'h0, 32'h0, 6'd0, 1'b1, 1'b1);
        idle(1'b1);
        check("clr_op_count", 64'(op_count), 64'd0);
        check("clr_approx_count", 64'(approx_count), 64'd0);

        // Eight back-to-back beats with out_ready low in cycles 3-5
        begin
            int sent, c;
            logic saw_low;
            sent    = 0;
            c       = 0;
            saw_low = 1'b0;
            while (sent < 8 && c < 40) begin
                step(1'b1, $urandom, $urandom, 6'($urandom_range(0, 20)),
                     !(c >= 3 && c <= 5), 1'b0);
                if (last_acc) sent++;
                if (!last_in_ready) saw_low = 1'b1;
                c++;
            end
            check("stall_sent", 64'(sent), 64'd8);
            check("stall_in_ready_dropped", 64'(saw_low), 64'd1);
        end
        drain("stall");
        check("stall_op_count", 64'(op_count), 64'd8);
        check("stall_op_model", 64'(op_count), 64'(op_m));

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, 6'($urandom_range(0, 40)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        drain("rand");
        check("rand_op_count", 64'(op_count), 64'(op_m));
        check("rand_approx_count", 64'(approx_count), 64'(apx_m));

        // Reset with two beats in flight
        step(1'b1, 32'h0000_0001, 32'h0000_0002, 6'd16, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0003, 32'h0000_0004, 6'd0, 1'b1, 1'b0);
        idle(1'b0);
        check("inflight_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_op_count", 64'(op_count), 64'd0);
        check("mid_rst_approx_count", 64'(approx_count), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        exp_q.delete();
        exp_apx_q.delete();
        op_m  = 0;
        apx_m = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            check($sformatf("post_rst_quiet%0d", i), 64'(out_valid), 64'd0);
        end
        step(1'b1, 32'h0000_00FF, 32'h0000_0001, 6'd8, 1'b1, 1'b0);
        idle(1'b1);
        check("post_rst_lat1", 64'(out_valid), 64'd0);
        idle(1'b1);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_sum", 64'(sum), 64'h0FF);
        drain("post_rst");
        check("post_rst_op_count", 64'(op_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
